// File: rtl/burst_arbiter_pkg.sv
// Shared types and defaults for the burst arbiter: FSM state encoding,
// default geometry and the index-width helper used for done_id/pointer.
package burst_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BURST   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_LEN_W   = 4;

   // A single requester still needs a 1-bit index port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/burst_arbiter_rr.sv
// Round-robin selector: first asserted request at or after pointer,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_arbiter
   import burst_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   index,
   output logic               any
);

   logic [IDX_W-1:0] pos;

   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      pos   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = IDX_W'((int'(pointer) + k) % NUM_REQ);
         if (!any && req[pos]) begin
            any        = 1'b1;
            grant[pos] = 1'b1;
            index      = pos;
         end
      end
   end

endmodule

// File: rtl/burst_arbiter.sv
// Grants one requester at a time a fixed-length enable burst on an external
// counting datapath, then captures the datapath value and pulses done.
module burst_arbiter
   import burst_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] burst_len,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     bus_enable,
   input  logic [DATA_W-1:0]        bus_data,
   output logic [DATA_W-1:0]        result,
   output logic                     done,
   output logic [IDX_W-1:0]         done_id,
   output logic                     busy
);

   state_t             state_reg, state_next;
   logic [LEN_W-1:0]   cnt_reg, cnt_next;
   logic [NUM_REQ-1:0] gnt_reg, gnt_next;
   logic               en_reg, en_next;
   logic               done_reg, done_next;
   logic               busy_reg, busy_next;
   logic [IDX_W-1:0]   done_id_reg, done_id_next;
   logic [IDX_W-1:0]   win_reg, win_next;
   logic [IDX_W-1:0]   ptr_reg, ptr_next;
   logic [DATA_W-1:0]  result_reg, result_next;

   logic [NUM_REQ-1:0] rr_grant;
   logic [IDX_W-1:0]   rr_index;
   logic               rr_any;

   logic [LEN_W-1:0]   len_field [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
      assign len_field[gi] = burst_len[gi*LEN_W +: LEN_W];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req     (req),
      .pointer (ptr_reg),
      .grant   (rr_grant),
      .index   (rr_index),
      .any     (rr_any)
   );

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      gnt_next     = gnt_reg;
      en_next      = en_reg;
      done_next    = 1'b0;
      done_id_next = done_id_reg;
      win_next     = win_reg;
      ptr_next     = ptr_reg;
      result_next  = result_reg;
      case (state_reg)
         IDLE: begin
            if (rr_any) begin
               gnt_next   = rr_grant;
               en_next    = 1'b1;
               cnt_next   = len_field[rr_index];
               win_next   = rr_index;
               ptr_next   = (rr_index == IDX_W'(NUM_REQ - 1)) ? '0 : rr_index + IDX_W'(1);
               state_next = BURST;
            end
         end
         BURST: begin
            // Counter holds remaining enable cycles after this one.
            if (cnt_reg == '0) begin
               en_next    = 1'b0;
               state_next = CAPTURE;
            end else begin
               cnt_next = cnt_reg - LEN_W'(1);
            end
         end
         CAPTURE: begin
            // Datapath still holds the burst count here; it clears this edge.
            result_next  = bus_data;
            done_next    = 1'b1;
            done_id_next = win_reg;
            gnt_next     = '0;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         gnt_reg     <= '0;
         en_reg      <= 1'b0;
         done_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_id_reg <= '0;
         win_reg     <= '0;
         ptr_reg     <= '0;
         result_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         gnt_reg     <= gnt_next;
         en_reg      <= en_next;
         done_reg    <= done_next;
         busy_reg    <= busy_next;
         done_id_reg <= done_id_next;
         win_reg     <= win_next;
         ptr_reg     <= ptr_next;
         result_reg  <= result_next;
      end
   end

   assign gnt        = gnt_reg;
   assign bus_enable = en_reg;
   assign done       = done_reg;
   assign done_id    = done_id_reg;
   assign busy       = busy_reg;
   assign result     = result_reg;

endmodule

// File: tb/tb_burst_arbiter.sv
// Bench for burst_arbiter with an increment/clear datapath; a transaction-
// timeline model predicts every output each cycle.
module tb_burst_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int LEN_W   = 4;

   localparam int M_HOLD = 0;
   localparam int M_DROP = 1;
   localparam int M_LEN  = 2;
   localparam int M_RAND = 3;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*LEN_W-1:0] burst_len;
   logic [NUM_REQ-1:0]       gnt;
   logic                     bus_enable;
   logic [DATA_W-1:0]        bus_data;
   logic [DATA_W-1:0]        result;
   logic                     done;
   logic [1:0]               done_id;
   logic                     busy;

   int n_checks = 0;
   int n_errors = 0;
   int s        = 0;

   // Model: one transaction at a time, described by grant sample and length.
   bit m_active = 0;
   int m_n      = 0;
   int m_win    = 0;
   int m_len    = 0;
   int m_ptr    = 0;
   int m_result = 0;
   int m_id     = 0;
   bit m_done   = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) bus_data <= bus_enable ? bus_data + 8'd1 : 8'd0;

   burst_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .LEN_W   (LEN_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .burst_len  (burst_len),
      .gnt        (gnt),
      .bus_enable (bus_enable),
      .bus_data   (bus_data),
      .result     (result),
      .done       (done),
      .done_id    (done_id),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at sample %0d: got %0h expected %0h", tag, s, got, exp);
      end
   endtask

   // Advance one edge; inputs seen by that edge are the current req/burst_len/rst.
   task automatic step();
      logic [NUM_REQ-1:0] exp_gnt;
      bit                 found;
      int                 j;
      @(negedge clk);
      s++;
      m_done = 0;
      if (rst) begin
         m_active = 0;
         m_ptr    = 0;
         m_result = 0;
         m_id     = 0;
      end else if (m_active) begin
         // Enable spans samples n..n+L, capture edge lands on n+L+2.
         if (s == m_n + m_len + 2) begin
            m_done   = 1;
            m_result = m_len + 1;
            m_id     = m_win;
            m_active = 0;
         end
      end else if (req != '0) begin
         found = 0;
         for (int k = 0; k < NUM_REQ; k++) begin
            j = (m_ptr + k) % NUM_REQ;
            if (!found && req[j]) begin
               found = 1;
               m_win = j;
            end
         end
         m_len    = int'(burst_len[m_win*LEN_W +: LEN_W]);
         m_n      = s;
         m_active = 1;
         m_ptr    = (m_win + 1) % NUM_REQ;
      end
      exp_gnt = m_active ? (NUM_REQ'(1) << m_win) : '0;
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("bus_enable", 32'(bus_enable), 32'(m_active && (s <= m_n + m_len)));
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
      check("result", 32'(result), m_result);
      check("done_id", 32'(done_id), m_id);
      if (m_done)
         $display("sample %0d: done id=%0d result=%0d", s, done_id, result);
   endtask

   task automatic run(input int ncyc, input int mode);
      for (int c = 0; c < ncyc; c++) begin
         step();
         case (mode)
            M_DROP: req = req & ~gnt;
            M_LEN: begin
               if (gnt != '0) begin
                  req       = req & ~gnt;
                  burst_len = {NUM_REQ{4'd7}};
               end
            end
            M_RAND: begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (gnt[i]) begin
                     if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                  end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                     req[i] = 1'b1;
                  end
               end
               burst_len = 16'($urandom());
               rst       = ($urandom_range(0, 299) == 0);
            end
            default: ;
         endcase
      end
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      burst_len = '0;
      run(3, M_HOLD);
      rst = 1'b0;

      // Single request, length 3.
      req = 4'b0001; burst_len = 16'h0002;
      run(10, M_DROP);

      // Full contention, single-cycle bursts.
      req = 4'b1111; burst_len = '0;
      run(24, M_HOLD);
      req = '0;
      run(4, M_HOLD);

      // Maximum length on requester 2.
      req = 4'b0100; burst_len = 16'h0F00;
      run(22, M_DROP);

      // Requester 1 drops request after grant.
      req = 4'b0010; burst_len = 16'h0040;
      run(10, M_DROP);

      // Length field changes mid-burst.
      req = 4'b0001; burst_len = 16'h0001;
      run(8, M_LEN);

      // Reset on the third enable cycle of a 10-cycle burst.
      req = 4'b0001; burst_len = 16'h0009;
      run(1, M_DROP);
      run(2, M_HOLD);
      rst = 1'b1;
      run(1, M_HOLD);
      rst = 1'b0;
      req = 4'b0011;
      run(20, M_DROP);

      req = '0;
      run(3000, M_RAND);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/burst_arbiter.md
BURST_ARBITER -- requirements
Module: burst_arbiter

Interface
REQ-001 SHALL take parameter NUM_REQ, default 4, number of requesters sharing the counting datapath.
REQ-002 SHALL take parameter DATA_W, default 8, datapath data width.
REQ-003 SHALL take parameter LEN_W, default 4, per-requester burst-length field width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester request level; requester holds it until its gnt bit is seen.
REQ-007 burst_len  input  NUM_REQ*LEN_W  packed; field i = requested enable cycles minus 1 for requester i.
REQ-008 gnt  output  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-009 bus_enable  output  1  drives the datapath enable (counter increments while high, clears while low).
REQ-010 bus_data  input  DATA_W  datapath data, read back at transaction end.
REQ-011 result  output  DATA_W  captured bus_data of the last completed transaction.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 done_id  output  clog2(NUM_REQ)  index of requester finished when done pulses.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, BURST, CAPTURE; all outputs registered.
REQ-016 IDLE: on an edge with any req bit set, SHALL select winner by round-robin, set gnt one-hot, set bus_enable=1, load length counter with winner's burst_len field, go to BURST.
REQ-017 Round-robin: search starts at index (last granted + 1) mod NUM_REQ; after reset search starts at index 0.
REQ-018 BURST: on each edge, if counter==0 SHALL set bus_enable=0 and go to CAPTURE, else decrement counter.
REQ-019 bus_enable SHALL be high for exactly burst_len+1 consecutive cycles per transaction (1..2^LEN_W).
REQ-020 CAPTURE: on the edge, SHALL register result<=bus_data, done<=1, done_id<=winner index, clear gnt, go to IDLE.
REQ-021 done SHALL deassert on the following edge; result and done_id SHALL hold until next capture.
REQ-022 bus_enable SHALL be low for at least 2 cycles (CAPTURE, IDLE) between transactions so the datapath clears to 0 before the next burst.
REQ-023 req changes during BURST/CAPTURE SHALL be ignored; transaction always runs to completion (no abort).
REQ-024 burst_len sampled only at grant; later changes do not affect the running burst.
REQ-025 A requester still asserting req after done is eligible again but loses to any other pending requester (round-robin).
REQ-026 Winner index and result width: result = bus_data unmodified; no arithmetic on data beyond capture.

Reset
REQ-027 rst high at an edge SHALL force state=IDLE, gnt=0, bus_enable=0, done=0, done_id=0, result=0, counter=0, round-robin pointer=0, in any state including mid-burst.
REQ-028 First grant evaluation SHALL occur on the first edge with rst low.

Structure
REQ-029 Shared package SHALL hold the state enum (IDLE, BURST, CAPTURE) and defaults for NUM_REQ, DATA_W, LEN_W.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, pointer; outputs one-hot grant, index, any).
REQ-031 Top level holds FSM, length counter, pointer and capture registers; datapath is external.

Verification (bench pairs block with an increment/clear counter datapath)
REQ-032 Single request: req=0001, burst_len[0]=2 -> bus_enable high 3 cycles, done pulses once, done_id=0, result=3.
REQ-033 Contention: req=1111 held, all burst_len=0 -> grant order 0,1,2,3,0; each result=1; enable gap >=2 cycles.
REQ-034 Max length: burst_len=15 on requester 2 -> 16 enable cycles, result=16, done_id=2.
REQ-035 Mid-burst reset: rst pulsed on 3rd enable cycle of a 10-cycle burst -> next cycle gnt=0, bus_enable=0, busy=0, done never pulses; next grant goes to index 0 first.
REQ-036 Request drop: requester 1 drops req after gnt with burst_len=4 -> burst still completes, result=5, done_id=1.
REQ-037 Length change: burst_len changed from 1 to 7 during BURST -> enable high 2 cycles, result=2.
